// File: rtl/pcie_ss_axis_pkg.sv
// AXI-S stream widths shared by the PCIe subsystem interfaces.
package pcie_ss_axis_pkg;

  localparam int unsigned TDATA_WIDTH = 512;
  localparam int unsigned TUSER_WIDTH = 10;

endpackage : pcie_ss_axis_pkg

// File: rtl/port_quiesce_pkg.sv
// State encodings and watchdog sizing for the per-port quiesce gate.
package port_quiesce_pkg;

  typedef enum logic [1:0] {
    TX_RUN      = 2'd0,
    TX_DRAIN    = 2'd1,
    TX_FORCE    = 2'd2,
    TX_QUIESCED = 2'd3
  } tx_state_e;

  typedef enum logic {
    RX_PASS = 1'b0,
    RX_DROP = 1'b1
  } rx_state_e;

  // Watchdog width able to hold the value DRAIN_TIMEOUT
  function automatic int unsigned wd_width(input int unsigned timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage : port_quiesce_pkg

// File: rtl/pcie_ss_axis_if.sv
// Minimal PCIe subsystem AXI-S interface with source/sink views.
interface pcie_ss_axis_if;

  logic                                      tvalid;
  logic                                      tready;
  logic                                      tlast;
  logic [pcie_ss_axis_pkg::TDATA_WIDTH-1:0]  tdata;
  logic [pcie_ss_axis_pkg::TUSER_WIDTH-1:0]  tuser;

  modport source (output tvalid, output tdata, output tuser, output tlast, input tready);
  modport sink   (input tvalid, input tdata, input tuser, input tlast, output tready);

endinterface : pcie_ss_axis_if

// File: rtl/port_quiesce_ch.sv
// One port of the quiesce gate: TX drain/force FSM, RX drop FSM,
// drain watchdog and optional RX drop counter.
// Optional feature macro: PORT_QUIESCE_DROP_CNT_EN (RX drop counter).
module port_quiesce_ch
  import port_quiesce_pkg::*;
#(
  parameter int unsigned DATA_W        = 512,
  parameter int unsigned USER_W        = 10,
  parameter int unsigned DRAIN_TIMEOUT = 1024,
  parameter int unsigned CNT_W         = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              quiesce_req_i,
  output logic              quiesced_o,
  output logic              err_timeout_o,
  output logic [CNT_W-1:0]  rx_drop_cnt_o,
  // TX from AFU
  input  logic              afu_tx_tvalid_i,
  output logic              afu_tx_tready_o,
  input  logic [DATA_W-1:0] afu_tx_tdata_i,
  input  logic [USER_W-1:0] afu_tx_tuser_i,
  input  logic              afu_tx_tlast_i,
  // TX to MUX
  output logic              mux_tx_tvalid_o,
  input  logic              mux_tx_tready_i,
  output logic [DATA_W-1:0] mux_tx_tdata_o,
  output logic [USER_W-1:0] mux_tx_tuser_o,
  output logic              mux_tx_tlast_o,
  // RX from MUX
  input  logic              mux_rx_tvalid_i,
  output logic              mux_rx_tready_o,
  input  logic [DATA_W-1:0] mux_rx_tdata_i,
  input  logic [USER_W-1:0] mux_rx_tuser_i,
  input  logic              mux_rx_tlast_i,
  // RX to AFU
  output logic              afu_rx_tvalid_o,
  input  logic              afu_rx_tready_i,
  output logic [DATA_W-1:0] afu_rx_tdata_o,
  output logic [USER_W-1:0] afu_rx_tuser_o,
  output logic              afu_rx_tlast_o
);

  localparam int unsigned WD_W = wd_width(DRAIN_TIMEOUT);

  tx_state_e       tx_q;
  rx_state_e       rx_q;
  logic            tx_open_q;
  logic            rx_open_q;
  logic [WD_W-1:0] wd_q;
  logic            err_q;
  logic            quiesced_q;

  logic            tx_fire;
  logic            rx_fire;
  logic            rx_open_nxt;

  // TX datapath: passthrough while a packet may flow, forced zero tlast beat on timeout
  always_comb begin
    mux_tx_tvalid_o = 1'b0;
    mux_tx_tdata_o  = '0;
    mux_tx_tuser_o  = '0;
    mux_tx_tlast_o  = 1'b0;
    afu_tx_tready_o = 1'b0;
    case (tx_q)
      TX_RUN: begin
        mux_tx_tvalid_o = afu_tx_tvalid_i;
        mux_tx_tdata_o  = afu_tx_tdata_i;
        mux_tx_tuser_o  = afu_tx_tuser_i;
        mux_tx_tlast_o  = afu_tx_tlast_i;
        afu_tx_tready_o = mux_tx_tready_i;
      end
      TX_DRAIN: begin
        // Only the open packet may finish; nothing new starts while draining
        if (tx_open_q) begin
          mux_tx_tvalid_o = afu_tx_tvalid_i;
          mux_tx_tdata_o  = afu_tx_tdata_i;
          mux_tx_tuser_o  = afu_tx_tuser_i;
          mux_tx_tlast_o  = afu_tx_tlast_i;
          afu_tx_tready_o = mux_tx_tready_i;
        end
      end
      TX_FORCE: begin
        mux_tx_tvalid_o = 1'b1;
        mux_tx_tlast_o  = 1'b1;
      end
      default: ;
    endcase
  end

  assign tx_fire = afu_tx_tvalid_i & afu_tx_tready_o;

  // TX state machine with drain watchdog and sticky timeout flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_q      <= TX_QUIESCED;
      tx_open_q <= 1'b0;
      wd_q      <= '0;
      err_q     <= 1'b0;
    end else begin
      case (tx_q)
        TX_RUN: begin
          if (tx_fire) tx_open_q <= !afu_tx_tlast_i;
          if (quiesce_req_i) begin
            wd_q <= '0;
            tx_q <= (!tx_open_q && !tx_fire) ? TX_QUIESCED : TX_DRAIN;
          end
        end
        TX_DRAIN: begin
          if (!tx_open_q) begin
            tx_q <= quiesce_req_i ? TX_QUIESCED : TX_RUN;
          end else if (tx_fire) begin
            wd_q <= '0;
            if (afu_tx_tlast_i) begin
              tx_open_q <= 1'b0;
              tx_q      <= quiesce_req_i ? TX_QUIESCED : TX_RUN;
            end
          end else if (wd_q == WD_W'(DRAIN_TIMEOUT - 1)) begin
            tx_q  <= TX_FORCE;
            err_q <= 1'b1;
          end else begin
            wd_q <= wd_q + WD_W'(1);
          end
        end
        TX_FORCE: begin
          if (mux_tx_tready_i) begin
            tx_open_q <= 1'b0;
            tx_q      <= TX_QUIESCED;
          end
        end
        default: begin
          if (!quiesce_req_i) tx_q <= TX_RUN;
        end
      endcase
    end
  end

  // RX datapath: passthrough in PASS, unconditional sink in DROP
  always_comb begin
    afu_rx_tvalid_o = 1'b0;
    afu_rx_tdata_o  = '0;
    afu_rx_tuser_o  = '0;
    afu_rx_tlast_o  = 1'b0;
    mux_rx_tready_o = 1'b1;
    if (rx_q == RX_PASS) begin
      afu_rx_tvalid_o = mux_rx_tvalid_i;
      afu_rx_tdata_o  = mux_rx_tdata_i;
      afu_rx_tuser_o  = mux_rx_tuser_i;
      afu_rx_tlast_o  = mux_rx_tlast_i;
      mux_rx_tready_o = afu_rx_tready_i;
    end
  end

  assign rx_fire     = mux_rx_tvalid_i & mux_rx_tready_o;
  assign rx_open_nxt = rx_fire ? !mux_rx_tlast_i : rx_open_q;

  // RX mode only changes at a packet boundary, following quiesce_req
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_q      <= RX_DROP;
      rx_open_q <= 1'b0;
    end else begin
      rx_open_q <= rx_open_nxt;
      if (!rx_open_nxt) rx_q <= quiesce_req_i ? RX_DROP : RX_PASS;
    end
  end

  // Fully quiesced: TX parked and RX sinking with no packet open
  always_ff @(posedge clk) begin
    if (!rst_n) quiesced_q <= 1'b1;
    else        quiesced_q <= (tx_q == TX_QUIESCED) && (rx_q == RX_DROP) && !rx_open_q;
  end

  assign quiesced_o    = quiesced_q;
  assign err_timeout_o = err_q;

`ifdef PORT_QUIESCE_DROP_CNT_EN
  logic             drop_last;
  logic [CNT_W-1:0] drop_cnt_q;

  assign drop_last = (rx_q == RX_DROP) & rx_fire & mux_rx_tlast_i;

  // Saturating count of RX packets sunk while dropping
  always_ff @(posedge clk) begin
    if (!rst_n)                         drop_cnt_q <= '0;
    else if (drop_last && !(&drop_cnt_q)) drop_cnt_q <= drop_cnt_q + CNT_W'(1);
  end

  assign rx_drop_cnt_o = drop_cnt_q;
`else
  assign rx_drop_cnt_o = '0;
`endif

endmodule : port_quiesce_ch

// File: rtl/port_traffic_quiesce.sv
// Multi-port PCIe AXI-S quiesce gate between the PF/VF MUX and the AFU ports.
// Optional feature macro: PORT_QUIESCE_DROP_CNT_EN (per-port RX drop counters).
module port_traffic_quiesce #(
  parameter int unsigned NUM_PORTS     = 4,
  parameter int unsigned DATA_W        = pcie_ss_axis_pkg::TDATA_WIDTH,
  parameter int unsigned USER_W        = pcie_ss_axis_pkg::TUSER_WIDTH,
  parameter int unsigned DRAIN_TIMEOUT = 1024,
  parameter int unsigned CNT_W         = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_PORTS-1:0]       quiesce_req,
  output logic [NUM_PORTS-1:0]       quiesced,
  output logic [NUM_PORTS-1:0]       err_timeout,
  output logic [NUM_PORTS*CNT_W-1:0] rx_drop_cnt,
  pcie_ss_axis_if.sink               afu_tx_if [NUM_PORTS],
  pcie_ss_axis_if.source             mux_tx_if [NUM_PORTS],
  pcie_ss_axis_if.sink               mux_rx_if [NUM_PORTS],
  pcie_ss_axis_if.source             afu_rx_if [NUM_PORTS]
);

  // One independent gate per port
  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    port_quiesce_ch #(
      .DATA_W        (DATA_W),
      .USER_W        (USER_W),
      .DRAIN_TIMEOUT (DRAIN_TIMEOUT),
      .CNT_W         (CNT_W)
    ) u_ch (
      .clk             (clk),
      .rst_n           (rst_n),
      .quiesce_req_i   (quiesce_req[p]),
      .quiesced_o      (quiesced[p]),
      .err_timeout_o   (err_timeout[p]),
      .rx_drop_cnt_o   (rx_drop_cnt[p*CNT_W +: CNT_W]),
      .afu_tx_tvalid_i (afu_tx_if[p].tvalid),
      .afu_tx_tready_o (afu_tx_if[p].tready),
      .afu_tx_tdata_i  (afu_tx_if[p].tdata),
      .afu_tx_tuser_i  (afu_tx_if[p].tuser),
      .afu_tx_tlast_i  (afu_tx_if[p].tlast),
      .mux_tx_tvalid_o (mux_tx_if[p].tvalid),
      .mux_tx_tready_i (mux_tx_if[p].tready),
      .mux_tx_tdata_o  (mux_tx_if[p].tdata),
      .mux_tx_tuser_o  (mux_tx_if[p].tuser),
      .mux_tx_tlast_o  (mux_tx_if[p].tlast),
      .mux_rx_tvalid_i (mux_rx_if[p].tvalid),
      .mux_rx_tready_o (mux_rx_if[p].tready),
      .mux_rx_tdata_i  (mux_rx_if[p].tdata),
      .mux_rx_tuser_i  (mux_rx_if[p].tuser),
      .mux_rx_tlast_i  (mux_rx_if[p].tlast),
      .afu_rx_tvalid_o (afu_rx_if[p].tvalid),
      .afu_rx_tready_i (afu_rx_if[p].tready),
      .afu_rx_tdata_o  (afu_rx_if[p].tdata),
      .afu_rx_tuser_o  (afu_rx_if[p].tuser),
      .afu_rx_tlast_o  (afu_rx_if[p].tlast)
    );
  end

endmodule : port_traffic_quiesce

// File: tb/tb_port_traffic_quiesce.sv
// Directed bench for port_traffic_quiesce: 4 ports, DRAIN_TIMEOUT=16, CNT_W=2.
module tb_port_traffic_quiesce;

  localparam int unsigned NP = 4;
  localparam int unsigned DW = pcie_ss_axis_pkg::TDATA_WIDTH;
  localparam int unsigned UW = pcie_ss_axis_pkg::TUSER_WIDTH;
  localparam int unsigned DT = 16;
  localparam int unsigned CW = 2;

  logic clk = 1'b0;
  logic rst_n;
  logic [NP-1:0]    qreq;
  logic [NP-1:0]    quiesced;
  logic [NP-1:0]    err_to;
  logic [NP*CW-1:0] drop_cnt;

  logic [NP-1:0] atx_v, atx_l, atx_r;
  logic [DW-1:0] atx_d [NP];
  logic [UW-1:0] atx_u [NP];
  logic [NP-1:0] mtx_v, mtx_l, mtx_r;
  logic [DW-1:0] mtx_d [NP];
  logic [UW-1:0] mtx_u [NP];
  logic [NP-1:0] mrx_v, mrx_l, mrx_r;
  logic [DW-1:0] mrx_d [NP];
  logic [UW-1:0] mrx_u [NP];
  logic [NP-1:0] arx_v, arx_l, arx_r;
  logic [DW-1:0] arx_d [NP];
  logic [UW-1:0] arx_u [NP];

  int total = 0;
  int bad   = 0;
  logic [NP*CW-1:0] exp_cnt;

  pcie_ss_axis_if afu_tx [NP] ();
  pcie_ss_axis_if mux_tx [NP] ();
  pcie_ss_axis_if mux_rx [NP] ();
  pcie_ss_axis_if afu_rx [NP] ();

  for (genvar g = 0; g < NP; g++) begin : g_if
    assign afu_tx[g].tvalid = atx_v[g];
    assign afu_tx[g].tdata  = atx_d[g];
    assign afu_tx[g].tuser  = atx_u[g];
    assign afu_tx[g].tlast  = atx_l[g];
    assign atx_r[g]         = afu_tx[g].tready;
    assign mtx_v[g]         = mux_tx[g].tvalid;
    assign mtx_d[g]         = mux_tx[g].tdata;
    assign mtx_u[g]         = mux_tx[g].tuser;
    assign mtx_l[g]         = mux_tx[g].tlast;
    assign mux_tx[g].tready = mtx_r[g];
    assign mux_rx[g].tvalid = mrx_v[g];
    assign mux_rx[g].tdata  = mrx_d[g];
    assign mux_rx[g].tuser  = mrx_u[g];
    assign mux_rx[g].tlast  = mrx_l[g];
    assign mrx_r[g]         = mux_rx[g].tready;
    assign arx_v[g]         = afu_rx[g].tvalid;
    assign arx_d[g]         = afu_rx[g].tdata;
    assign arx_u[g]         = afu_rx[g].tuser;
    assign arx_l[g]         = afu_rx[g].tlast;
    assign afu_rx[g].tready = arx_r[g];
  end

  port_traffic_quiesce #(
    .NUM_PORTS     (NP),
    .DATA_W        (DW),
    .USER_W        (UW),
    .DRAIN_TIMEOUT (DT),
    .CNT_W         (CW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .quiesce_req (qreq),
    .quiesced    (quiesced),
    .err_timeout (err_to),
    .rx_drop_cnt (drop_cnt),
    .afu_tx_if   (afu_tx),
    .mux_tx_if   (mux_tx),
    .mux_rx_if   (mux_rx),
    .afu_rx_if   (afu_rx)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    total++; if (quiesced !== 4'hF) begin bad++; $display("FAIL rst_quiesced: got %b want 1111", quiesced); end
    total++; if (err_to !== 4'h0) begin bad++; $display("FAIL rst_err: got %b want 0000", err_to); end
    total++; if (drop_cnt !== '0) begin bad++; $display("FAIL rst_cnt: got %h want 0", drop_cnt); end
    total++; if (mtx_v !== 4'h0) begin bad++; $display("FAIL rst_mtx_valid: got %b want 0000", mtx_v); end
    total++; if (atx_r !== 4'h0) begin bad++; $display("FAIL rst_atx_ready: got %b want 0000", atx_r); end
    total++; if (mrx_r !== 4'hF) begin bad++; $display("FAIL rst_mrx_ready: got %b want 1111", mrx_r); end
    total++; if (arx_v !== 4'h0) begin bad++; $display("FAIL rst_arx_valid: got %b want 0000", arx_v); end
    rst_n = 1'b1;
    step();
    total++; if (quiesced !== 4'hF) begin bad++; $display("FAIL rel1_quiesced: got %b want 1111", quiesced); end
    step();
    total++; if (quiesced !== 4'h0) begin bad++; $display("FAIL rel2_quiesced: got %b want 0000", quiesced); end
    total++; if (atx_r !== 4'hF) begin bad++; $display("FAIL run_atx_ready: got %b want 1111", atx_r); end
  endtask

  task automatic test_tx_pass();
    for (int i = 0; i < 4; i++) begin
      atx_v[0] = 1'b1; atx_d[0] = DW'(32'hA0 + i); atx_u[0] = UW'(i + 1); atx_l[0] = (i == 3);
      #1;
      total++; if (mtx_v[0] !== 1'b1 || mtx_d[0] !== DW'(32'hA0 + i) || mtx_u[0] !== UW'(i + 1))
        begin bad++; $display("FAIL tx_pass beat%0d: got v=%b d=%0h u=%0h", i, mtx_v[0], mtx_d[0], mtx_u[0]); end
      total++; if (mtx_l[0] !== (i == 3)) begin bad++; $display("FAIL tx_pass_last beat%0d: got %b", i, mtx_l[0]); end
      step();
    end
    atx_v[0] = 1'b0; atx_l[0] = 1'b0;
    // Backpressure from the MUX flows straight back to the AFU
    mtx_r[0] = 1'b0;
    #1;
    total++; if (atx_r[0] !== 1'b0) begin bad++; $display("FAIL tx_backpressure: got %b want 0", atx_r[0]); end
    mtx_r[0] = 1'b1;
    // RX passthrough on port 0
    mrx_v[0] = 1'b1; mrx_d[0] = DW'(32'h55); mrx_u[0] = UW'(3); mrx_l[0] = 1'b1;
    #1;
    total++; if (arx_v[0] !== 1'b1 || arx_d[0] !== DW'(32'h55) || arx_u[0] !== UW'(3) || arx_l[0] !== 1'b1)
      begin bad++; $display("FAIL rx_pass: got v=%b d=%0h u=%0h l=%b", arx_v[0], arx_d[0], arx_u[0], arx_l[0]); end
    arx_r[0] = 1'b0;
    #1;
    total++; if (mrx_r[0] !== 1'b0) begin bad++; $display("FAIL rx_backpressure: got %b want 0", mrx_r[0]); end
    arx_r[0] = 1'b1;
    mrx_v[0] = 1'b0;
    step();
  endtask

  task automatic test_drain();
    for (int i = 0; i < 4; i++) begin
      atx_v[1] = 1'b1; atx_d[1] = DW'(32'hB0 + i); atx_l[1] = (i == 3);
      if (i == 1) qreq[1] = 1'b1;
      atx_v[2] = 1'b1; atx_d[2] = DW'(32'hC0 + i); atx_l[2] = 1'b1;
      #1;
      total++; if (mtx_v[1] !== 1'b1 || mtx_d[1] !== DW'(32'hB0 + i) || atx_r[1] !== 1'b1)
        begin bad++; $display("FAIL drain_beat%0d: got v=%b d=%0h r=%b", i, mtx_v[1], mtx_d[1], atx_r[1]); end
      total++; if (mtx_v[2] !== 1'b1 || mtx_d[2] !== DW'(32'hC0 + i))
        begin bad++; $display("FAIL other_port beat%0d: got v=%b d=%0h", i, mtx_v[2], mtx_d[2]); end
      step();
    end
    atx_v[2] = 1'b0;
    // A new packet after the drained tlast is blocked
    atx_v[1] = 1'b1; atx_d[1] = DW'(32'hBF); atx_l[1] = 1'b0;
    #1;
    total++; if (mtx_v[1] !== 1'b0 || atx_r[1] !== 1'b0)
      begin bad++; $display("FAIL drain_block: got v=%b r=%b want 0 0", mtx_v[1], atx_r[1]); end
    step();
    total++; if (quiesced !== 4'b0010) begin bad++; $display("FAIL drain_quiesced: got %b want 0010", quiesced); end
    total++; if (err_to !== 4'b0000) begin bad++; $display("FAIL drain_err: got %b want 0000", err_to); end
    atx_v[1] = 1'b0;
    qreq[1] = 1'b0;
    step();
    step();
    total++; if (quiesced !== 4'b0000) begin bad++; $display("FAIL drain_release: got %b want 0000", quiesced); end
  endtask

  task automatic test_drain_abort();
    atx_v[3] = 1'b1; atx_d[3] = DW'(32'hD0); atx_l[3] = 1'b0;
    step();
    atx_v[3] = 1'b0; qreq[3] = 1'b1;
    step();
    qreq[3] = 1'b0;
    atx_v[3] = 1'b1; atx_d[3] = DW'(32'hD1); atx_l[3] = 1'b1;
    #1;
    total++; if (mtx_v[3] !== 1'b1 || mtx_d[3] !== DW'(32'hD1))
      begin bad++; $display("FAIL abort_tail: got v=%b d=%0h", mtx_v[3], mtx_d[3]); end
    step();
    atx_d[3] = DW'(32'hD2);
    #1;
    total++; if (mtx_v[3] !== 1'b1 || atx_r[3] !== 1'b1)
      begin bad++; $display("FAIL abort_run: got v=%b r=%b want 1 1", mtx_v[3], atx_r[3]); end
    total++; if (quiesced[3] !== 1'b0) begin bad++; $display("FAIL abort_quiesced: got %b want 0", quiesced[3]); end
    step();
    atx_v[3] = 1'b0; atx_l[3] = 1'b0;
  endtask

  task automatic test_watchdog();
    atx_v[2] = 1'b1; atx_d[2] = DW'(32'hE0); atx_l[2] = 1'b0;
    step();
    atx_v[2] = 1'b0; qreq[2] = 1'b1;
    step();
    for (int i = 0; i < int'(DT); i++) begin
      total++; if (mtx_v[2] !== 1'b0 || err_to[2] !== 1'b0)
        begin bad++; $display("FAIL wd_wait cyc%0d: got v=%b err=%b want 0 0", i, mtx_v[2], err_to[2]); end
      step();
    end
    mtx_r[2] = 1'b0;
    atx_v[2] = 1'b1; atx_d[2] = DW'(32'hE1); atx_u[2] = UW'(5);
    #1;
    total++; if (mtx_v[2] !== 1'b1 || mtx_l[2] !== 1'b1 || mtx_d[2] !== '0 || mtx_u[2] !== '0)
      begin bad++; $display("FAIL wd_force: got v=%b l=%b d=%0h u=%0h", mtx_v[2], mtx_l[2], mtx_d[2], mtx_u[2]); end
    total++; if (atx_r[2] !== 1'b0) begin bad++; $display("FAIL wd_force_ready: got %b want 0", atx_r[2]); end
    total++; if (err_to !== 4'b0100) begin bad++; $display("FAIL wd_err: got %b want 0100", err_to); end
    step();
    total++; if (mtx_v[2] !== 1'b1) begin bad++; $display("FAIL wd_force_hold: got %b want 1", mtx_v[2]); end
    mtx_r[2] = 1'b1;
    step();
    total++; if (mtx_v[2] !== 1'b0 || atx_r[2] !== 1'b0)
      begin bad++; $display("FAIL wd_parked: got v=%b r=%b want 0 0", mtx_v[2], atx_r[2]); end
    step();
    total++; if (quiesced !== 4'b0100) begin bad++; $display("FAIL wd_quiesced: got %b want 0100", quiesced); end
    atx_v[2] = 1'b0; qreq[2] = 1'b0;
    step();
    step();
    total++; if (err_to !== 4'b0100) begin bad++; $display("FAIL wd_sticky: got %b want 0100", err_to); end
  endtask

  task automatic test_rx_drop();
    int lens [5] = '{2, 1, 5, 1, 1};
    qreq[3] = 1'b1;
    arx_r[3] = 1'b0;
    step();
    step();
    total++; if (quiesced !== 4'b1000) begin bad++; $display("FAIL rxq_quiesced: got %b want 1000", quiesced); end
    for (int p = 0; p < 5; p++) begin
      for (int b = 0; b < lens[p]; b++) begin
        mrx_v[3] = 1'b1; mrx_d[3] = DW'(32'h100 * p + b); mrx_l[3] = (b == lens[p] - 1);
        #1;
        total++; if (mrx_r[3] !== 1'b1 || arx_v[3] !== 1'b0)
          begin bad++; $display("FAIL rx_drop p%0d b%0d: got r=%b v=%b want 1 0", p, b, mrx_r[3], arx_v[3]); end
        step();
      end
      if (p == 2) begin
        mrx_v[3] = 1'b0;
`ifdef PORT_QUIESCE_DROP_CNT_EN
        exp_cnt = {2'd3, 2'd0, 2'd0, 2'd0};
`else
        exp_cnt = '0;
`endif
        total++; if (drop_cnt !== exp_cnt) begin bad++; $display("FAIL drop_cnt3: got %h want %h", drop_cnt, exp_cnt); end
      end
    end
    mrx_v[3] = 1'b0;
    total++; if (drop_cnt !== exp_cnt) begin bad++; $display("FAIL drop_cnt_sat: got %h want %h", drop_cnt, exp_cnt); end
    arx_r[3] = 1'b1;
  endtask

  task automatic test_rx_release();
    for (int b = 0; b < 3; b++) begin
      mrx_v[3] = 1'b1; mrx_d[3] = DW'(32'h300 + b); mrx_l[3] = (b == 2);
      if (b == 1) qreq[3] = 1'b0;
      #1;
      total++; if (arx_v[3] !== 1'b0 || mrx_r[3] !== 1'b1)
        begin bad++; $display("FAIL rel_drop b%0d: got v=%b r=%b want 0 1", b, arx_v[3], mrx_r[3]); end
      step();
    end
    for (int b = 0; b < 2; b++) begin
      mrx_v[3] = 1'b1; mrx_d[3] = DW'(32'h400 + b); mrx_l[3] = (b == 1);
      #1;
      total++; if (arx_v[3] !== 1'b1 || arx_d[3] !== DW'(32'h400 + b) || arx_l[3] !== (b == 1))
        begin bad++; $display("FAIL rel_pass b%0d: got v=%b d=%0h l=%b", b, arx_v[3], arx_d[3], arx_l[3]); end
      step();
    end
    mrx_v[3] = 1'b0;
    total++; if (drop_cnt !== exp_cnt) begin bad++; $display("FAIL rel_cnt: got %h want %h", drop_cnt, exp_cnt); end
    step();
    total++; if (quiesced !== 4'b0000) begin bad++; $display("FAIL final_quiesced: got %b want 0000", quiesced); end
  endtask

  initial begin
    rst_n = 1'b0;
    qreq  = '0;
    atx_v = '0; atx_l = '0; mtx_r = '1;
    mrx_v = '0; mrx_l = '0; arx_r = '1;
    exp_cnt = '0;
    for (int i = 0; i < int'(NP); i++) begin
      atx_d[i] = '0; atx_u[i] = '0; mrx_d[i] = '0; mrx_u[i] = '0;
    end
    step();
    test_reset();
    test_tx_pass();
    test_drain();
    test_drain_abort();
    test_watchdog();
    test_rx_drop();
    test_rx_release();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_port_traffic_quiesce
